// File: rtl/ndp_trim_arb_if.sv
// Lane-input and merged-output bundle for the NDP trim/arbiter block.
// The master side drives lane words and out_ready; the slave side (the arbiter) drives the
// merged output stream and the statistics counters.
interface ndp_trim_arb_if #(
    parameter int unsigned DATA_WIDTH     = 480,
    parameter int unsigned CTRL_WIDTH     = 32,
    parameter int unsigned NUM_OUT_QUEUES = 8
);
    localparam int unsigned PortW = $clog2(NUM_OUT_QUEUES);

    logic [NUM_OUT_QUEUES-1:0]            in_valid;
    logic [NUM_OUT_QUEUES*CTRL_WIDTH-1:0] in_ctl;
    logic [NUM_OUT_QUEUES*DATA_WIDTH-1:0] in_data;
    logic [NUM_OUT_QUEUES-1:0]            trim_req;

    logic                  out_valid;
    logic                  out_ready;
    logic [CTRL_WIDTH-1:0] out_ctl;
    logic [DATA_WIDTH-1:0] out_data;
    logic [PortW-1:0]      out_port;

    logic [31:0] trim_count;
    logic [31:0] drop_count;

    modport master (
        output in_valid, in_ctl, in_data, trim_req, out_ready,
        input  out_valid, out_ctl, out_data, out_port, trim_count, drop_count
    );

    modport slave (
        input  in_valid, in_ctl, in_data, trim_req, out_ready,
        output out_valid, out_ctl, out_data, out_port, trim_count, drop_count
    );
endinterface

// File: rtl/ndp_trim_arb.sv
// NDP trim + round-robin merge.
// Each lane captures one word per cycle into a single-entry hold register, trimming congested
// payloads to header-only on the way in. A registered valid/ready output stage drains the hold
// registers round-robin. Lane inputs cannot be backpressured: a word arriving at an occupied,
// ungranted hold register is dropped and counted.
module ndp_trim_arb #(
    parameter int unsigned DATA_WIDTH     = 480,
    parameter int unsigned CTRL_WIDTH     = 32,
    parameter int unsigned NUM_OUT_QUEUES = 8,
    parameter int unsigned HDR_BYTES      = 20
) (
    input logic           clk,
    input logic           rst,
    ndp_trim_arb_if.slave bus
);
    localparam int unsigned PortW    = $clog2(NUM_OUT_QUEUES);
    localparam int unsigned HdrBits  = HDR_BYTES * 8;
    localparam int unsigned ZeroBits = DATA_WIDTH - HdrBits;
    localparam int unsigned CntW     = $clog2(NUM_OUT_QUEUES + 1);
    localparam logic [11:0] HdrLen   = 12'(HDR_BYTES);

    typedef logic [CTRL_WIDTH-1:0] ctl_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    // Lane hold registers
    logic [NUM_OUT_QUEUES-1:0] hold_vld_q;
    logic [NUM_OUT_QUEUES-1:0] hold_vld_d;
    ctl_t                      hold_ctl_q  [NUM_OUT_QUEUES];
    data_t                     hold_data_q [NUM_OUT_QUEUES];

    // Capture-side (post-trim) view of each lane's incoming word
    ctl_t                      cap_ctl  [NUM_OUT_QUEUES];
    data_t                     cap_data [NUM_OUT_QUEUES];
    logic [NUM_OUT_QUEUES-1:0] cap_trim;
    logic [NUM_OUT_QUEUES-1:0] cap_load;
    logic [NUM_OUT_QUEUES-1:0] cap_drop;

    // Output stage
    logic             out_valid_q;
    ctl_t             out_ctl_q;
    data_t            out_data_q;
    logic [PortW-1:0] out_port_q;
    logic [PortW-1:0] rr_q;

    // Arbitration
    logic                      advance;
    logic                      grant_vld;
    logic [PortW-1:0]          grant_idx;
    logic [PortW-1:0]          scan_idx;
    logic [NUM_OUT_QUEUES-1:0] grant_oh;

    // Statistics
    logic [31:0]     trim_count_q;
    logic [31:0]     drop_count_q;
    logic [CntW-1:0] n_trim;
    logic [CntW-1:0] n_drop;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CntW-1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Unpack lanes and apply the header-only trim to words that qualify.
    always_comb begin
        for (int i = 0; i < NUM_OUT_QUEUES; i++) begin
            cap_ctl[i]  = bus.in_ctl[i*CTRL_WIDTH +: CTRL_WIDTH];
            cap_data[i] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            cap_trim[i] = 1'b0;
            // Already-trimmed or header-sized words are left alone.
            if (bus.trim_req[i] && !cap_ctl[i][12] && (cap_ctl[i][11:0] > HdrLen)) begin
                cap_trim[i]        = 1'b1;
                cap_ctl[i][11:0]   = HdrLen;
                cap_ctl[i][12]     = 1'b1;
                for (int b = 0; b < ZeroBits; b++) begin
                    cap_data[i][b] = 1'b0;
                end
            end
        end
    end

    // Round-robin scan: first valid hold register at or after the pointer, wrapping.
    always_comb begin
        advance   = !out_valid_q || bus.out_ready;
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_OUT_QUEUES; k++) begin
            // PortW-bit add wraps naturally because the lane count is a power of two.
            scan_idx = rr_q + PortW'(k);
            if (!grant_vld && hold_vld_q[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // Decide per lane whether the incoming word loads or is dropped, and count events.
    always_comb begin
        grant_oh = '0;
        if (advance && grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
        // A lane being granted this edge frees its slot for a same-edge reload.
        cap_load   = bus.in_valid & (~hold_vld_q | grant_oh);
        cap_drop   = bus.in_valid & hold_vld_q & ~grant_oh;
        hold_vld_d = (hold_vld_q & ~grant_oh) | bus.in_valid;
        n_trim     = '0;
        n_drop     = '0;
        for (int i = 0; i < NUM_OUT_QUEUES; i++) begin
            n_trim = n_trim + CntW'(cap_trim[i] & cap_load[i]);
            n_drop = n_drop + CntW'(cap_drop[i]);
        end
    end

    // Lane hold registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_vld_q <= '0;
            for (int i = 0; i < NUM_OUT_QUEUES; i++) begin
                hold_ctl_q[i]  <= '0;
                hold_data_q[i] <= '0;
            end
        end else begin
            hold_vld_q <= hold_vld_d;
            for (int i = 0; i < NUM_OUT_QUEUES; i++) begin
                if (cap_load[i]) begin
                    hold_ctl_q[i]  <= cap_ctl[i];
                    hold_data_q[i] <= cap_data[i];
                end
            end
        end
    end

    // Registered output stage and round-robin pointer; frozen while the sink stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_ctl_q   <= '0;
            out_data_q  <= '0;
            out_port_q  <= '0;
            rr_q        <= '0;
        end else if (advance) begin
            if (grant_vld) begin
                out_valid_q <= 1'b1;
                out_ctl_q   <= hold_ctl_q[grant_idx];
                out_data_q  <= hold_data_q[grant_idx];
                out_port_q  <= grant_idx;
                rr_q        <= grant_idx + PortW'(1);
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Saturating trim/drop statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trim_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            trim_count_q <= sat_add(trim_count_q, n_trim);
            drop_count_q <= sat_add(drop_count_q, n_drop);
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_ctl    = out_ctl_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_port   = out_port_q;
    assign bus.trim_count = trim_count_q;
    assign bus.drop_count = drop_count_q;
endmodule
